// File: rtl/npu_pkg.sv
// Shared types and default sizing for the NPU layer sequencer.
package npu_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LD0   = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_WB    = 3'd4,
      S_LD1   = 3'd5,
      S_OUT   = 3'd6,
      S_DONE  = 3'd7
   } npu_ctrl_state_e;

   localparam int DEF_SIZE       = 4;
   localparam int DEF_MAX_LAYERS = 8;
   localparam int SEL_W          = $clog2(DEF_SIZE);
   localparam int LW             = $clog2(DEF_MAX_LAYERS + 1);

endpackage

// File: rtl/npu_lat_counter.sv
// Modulo-TERM up-counter with load-to-zero and terminal-count flag.
module npu_lat_counter #(
   parameter  int TERM = 4,
   localparam int W    = (TERM > 1) ? $clog2(TERM) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == W'(TERM - 1));

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= tc ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/npu_layer_ctrl.sv
// Multi-layer sequencer: load, stream through MACs, drain, write back or
// hand results to the host.
module npu_layer_ctrl
   import npu_pkg::*;
#(
   parameter  int SIZE       = DEF_SIZE,
   parameter  int MAC_LAT    = 3,
   parameter  int MAX_LAYERS = DEF_MAX_LAYERS,
   localparam int SW         = $clog2(SIZE),
   localparam int LNW        = $clog2(MAX_LAYERS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LNW-1:0]  cfg_nlayers,
   input  logic            load_done,
   input  logic            x_load_val,
   input  logic            w_load_val,
   input  logic [SW-1:0]   w_load_sel,
   input  logic            x_fifo_empty,
   input  logic [SIZE-1:0] w_fifo_empty,
   input  logic            out_rdy,
   output logic            x_sel,
   output logic            x_fifo_wen,
   output logic [SIZE-1:0] w_fifo_wen,
   output logic            x_fifo_ren,
   output logic            w_fifo_ren,
   output logic            istream_val,
   output logic [SW-1:0]   ostream_sel,
   output logic            mac_rst,
   output logic            out_val,
   output logic            busy,
   output logic            done,
   output logic [LNW-1:0]  layer_idx,
   output logic [3:0]      trace_state
);

   npu_ctrl_state_e state;
   logic [LNW-1:0]  nlayers;
   logic            empty, lat_tc, idx_tc, ld, last_layer;

   assign empty      = x_fifo_empty & (&w_fifo_empty);
   assign ld         = (state == S_LD0) || (state == S_LD1);
   assign last_layer = (layer_idx == nlayers - LNW'(1));

   // Latency counter sits at zero outside DRAIN, so every DRAIN starts fresh.
   npu_lat_counter #(.TERM(MAC_LAT)) u_lat (
      .clk (clk),
      .rst (rst),
      .clr (state != S_DRAIN),
      .en  (state == S_DRAIN),
      .cnt (),
      .tc  (lat_tc)
   );

   npu_lat_counter #(.TERM(SIZE)) u_idx (
      .clk (clk),
      .rst (rst),
      .clr ((state == S_IDLE) || (state == S_DRAIN && lat_tc)),
      .en  ((state == S_WB) || (state == S_OUT && out_rdy)),
      .cnt (ostream_sel),
      .tc  (idx_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         nlayers   <= LNW'(1);
         layer_idx <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               nlayers   <= (cfg_nlayers == '0) ? LNW'(1) : cfg_nlayers;
               layer_idx <= '0;
               state     <= S_LD0;
            end
            S_LD0, S_LD1: if (load_done) state <= S_MAC;
            S_MAC:        if (empty) state <= S_DRAIN;
            S_DRAIN:      if (lat_tc) state <= last_layer ? S_OUT : S_WB;
            S_WB: if (idx_tc) begin
               layer_idx <= layer_idx + LNW'(1);
               state     <= S_LD1;
            end
            S_OUT:        if (out_rdy && idx_tc) state <= S_DONE;
            default:      state <= S_IDLE;
         endcase
      end
   end

   // Load strobes pass straight through so a word coincident with load_done lands.
   always_comb begin
      w_fifo_wen = '0;
      for (int i = 0; i < SIZE; i++)
         if (ld && w_load_val && int'(w_load_sel) == i) w_fifo_wen[i] = 1'b1;
   end

   assign x_sel       = (state == S_WB);
   assign x_fifo_wen  = ((state == S_LD0) && x_load_val) || (state == S_WB);
   assign istream_val = (state == S_MAC) && !empty;
   assign x_fifo_ren  = istream_val;
   assign w_fifo_ren  = istream_val;
   assign mac_rst     = idx_tc && ((state == S_WB) || (state == S_OUT && out_rdy));
   assign out_val     = (state == S_OUT);
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign trace_state = {1'b0, state};

endmodule

// File: tb/tb_npu_layer_ctrl.sv
// Directed bench for npu_layer_ctrl with a simple FIFO occupancy model.
module tb_npu_layer_ctrl;

   localparam int SIZE = 4;
   localparam int LNW  = 4;
   localparam int SW   = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0, load_done = 1'b0, x_load_val = 1'b0, w_load_val = 1'b0;
   logic [LNW-1:0]  cfg_nlayers = '0;
   logic [SW-1:0]   w_load_sel = '0;
   logic            x_fifo_empty, out_rdy = 1'b0;
   logic [SIZE-1:0] w_fifo_empty;
   logic            x_sel, x_fifo_wen, x_fifo_ren, w_fifo_ren, istream_val;
   logic [SIZE-1:0] w_fifo_wen;
   logic [SW-1:0]   ostream_sel;
   logic            mac_rst, out_val, busy, done;
   logic [LNW-1:0]  layer_idx;
   logic [3:0]      trace_state;

   // SIZE=8 instance, used only for wide weight-select decoding
   logic            b_start = 1'b0, b_w_load_val = 1'b0;
   logic [2:0]      b_w_load_sel = '0;
   logic [7:0]      b_w_fifo_wen;
   logic            b_x_sel, b_x_fifo_wen, b_x_fifo_ren, b_w_fifo_ren, b_istream_val;
   logic [2:0]      b_ostream_sel;
   logic            b_mac_rst, b_out_val, b_busy, b_done;
   logic [LNW-1:0]  b_layer_idx;
   logic [3:0]      b_trace_state;

   int tests = 0, fails = 0;
   int x_cnt;
   int w_cnt [SIZE];

   always #5 clk = ~clk;

   npu_layer_ctrl #(.SIZE(SIZE), .MAC_LAT(3), .MAX_LAYERS(8)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_nlayers(cfg_nlayers),
      .load_done(load_done), .x_load_val(x_load_val), .w_load_val(w_load_val),
      .w_load_sel(w_load_sel), .x_fifo_empty(x_fifo_empty), .w_fifo_empty(w_fifo_empty),
      .out_rdy(out_rdy), .x_sel(x_sel), .x_fifo_wen(x_fifo_wen), .w_fifo_wen(w_fifo_wen),
      .x_fifo_ren(x_fifo_ren), .w_fifo_ren(w_fifo_ren), .istream_val(istream_val),
      .ostream_sel(ostream_sel), .mac_rst(mac_rst), .out_val(out_val), .busy(busy),
      .done(done), .layer_idx(layer_idx), .trace_state(trace_state)
   );

   npu_layer_ctrl #(.SIZE(8), .MAC_LAT(3), .MAX_LAYERS(8)) dut8 (
      .clk(clk), .rst(rst), .start(b_start), .cfg_nlayers(4'd1),
      .load_done(1'b0), .x_load_val(1'b0), .w_load_val(b_w_load_val),
      .w_load_sel(b_w_load_sel), .x_fifo_empty(1'b1), .w_fifo_empty(8'hFF),
      .out_rdy(1'b0), .x_sel(b_x_sel), .x_fifo_wen(b_x_fifo_wen), .w_fifo_wen(b_w_fifo_wen),
      .x_fifo_ren(b_x_fifo_ren), .w_fifo_ren(b_w_fifo_ren), .istream_val(b_istream_val),
      .ostream_sel(b_ostream_sel), .mac_rst(b_mac_rst), .out_val(b_out_val), .busy(b_busy),
      .done(b_done), .layer_idx(b_layer_idx), .trace_state(b_trace_state)
   );

   // FIFO occupancy model feeding the empty flags
   always @(posedge clk) begin
      if (rst) begin
         x_cnt <= 0;
         for (int i = 0; i < SIZE; i++) w_cnt[i] <= 0;
      end else begin
         x_cnt <= x_cnt + int'(x_fifo_wen) - int'(x_fifo_ren && x_cnt > 0);
         for (int i = 0; i < SIZE; i++)
            w_cnt[i] <= w_cnt[i] + int'(w_fifo_wen[i]) - int'(w_fifo_ren && w_cnt[i] > 0);
      end
   end

   assign x_fifo_empty = (x_cnt == 0);
   always_comb
      for (int i = 0; i < SIZE; i++) w_fifo_empty[i] = (w_cnt[i] == 0);

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({x_sel, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren, istream_val,
                  ostream_sel, mac_rst, out_val, busy, done, layer_idx, trace_state});
   endfunction

   task automatic load_layer(input bit with_x);
      for (int i = 0; i < SIZE; i++) begin
         x_load_val = 1'b1;
         w_load_val = 1'b1;
         w_load_sel = SW'(i);
         load_done  = (i == SIZE - 1);
         #1;
         chk("ld_xwen", 32'(x_fifo_wen), 32'(with_x));
         chk("ld_wwen", 32'(w_fifo_wen), 32'(1) << i);
         tick();
      end
      x_load_val = 1'b0;
      w_load_val = 1'b0;
      load_done  = 1'b0;
   endtask

   task automatic count_state(input logic [3:0] st, output int cyc, output int iss);
      cyc = 0;
      iss = 0;
      while (trace_state == st && cyc < 64) begin
         if (istream_val) iss++;
         cyc++;
         tick();
      end
      if (cyc == 64) chk("state_timeout", 32'(trace_state), 32'hF);
   endtask

   task automatic out_fast();
      out_rdy = 1'b1;
      for (int k = 0; k < SIZE; k++) begin
         #1;
         chk("out_val", 32'(out_val), 32'd1);
         chk("out_sel", 32'(ostream_sel), 32'(k));
         chk("out_mrst", 32'(mac_rst), 32'(k == SIZE - 1));
         tick();
      end
      out_rdy = 1'b0;
      #1;
      chk("done_state", 32'(trace_state), 32'd7);
      chk("done_pulse", 32'(done), 32'd1);
      tick();
      chk("back_idle", 32'(trace_state), 32'd0);
      chk("done_clear", 32'(done), 32'd0);
   endtask

   initial begin
      int cyc, iss, hs;

      // Reset state
      tick();
      tick();
      chk("rst_outs", all_outs(), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_outs", all_outs(), 32'd0);

      // Single layer, plus SIZE=8 select decoding
      cfg_nlayers = 4'd1;
      start = 1'b1;
      b_start = 1'b1;
      tick();
      start = 1'b0;
      b_start = 1'b0;
      chk("t1_ld0", 32'(trace_state), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("s8_ld0", 32'(b_trace_state), 32'd1);
      b_w_load_val = 1'b1;
      b_w_load_sel = 3'd7;
      #1;
      chk("s8_sel7", 32'(b_w_fifo_wen), 32'h80);
      b_w_load_sel = 3'd3;
      #1;
      chk("s8_sel3", 32'(b_w_fifo_wen), 32'h08);
      b_w_load_val = 1'b0;
      load_layer(1'b1);
      count_state(4'd2, cyc, iss);
      chk("t1_issue", 32'(iss), 32'd4);
      count_state(4'd3, cyc, iss);
      chk("t1_drain", 32'(cyc), 32'd3);
      chk("t1_out", 32'(trace_state), 32'd6);
      out_fast();

      // Three layers with writeback, then back-pressured output
      cfg_nlayers = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_layer(1'b1);
      for (int l = 0; l < 2; l++) begin
         count_state(4'd2, cyc, iss);
         chk("t2_issue", 32'(iss), 32'd4);
         count_state(4'd3, cyc, iss);
         chk("t2_drain", 32'(cyc), 32'd3);
         chk("t2_wb", 32'(trace_state), 32'd4);
         for (int k = 0; k < SIZE; k++) begin
            chk("wb_xwen", 32'({x_fifo_wen, x_sel}), 32'd3);
            chk("wb_sel", 32'(ostream_sel), 32'(k));
            chk("wb_mrst", 32'(mac_rst), 32'(k == SIZE - 1));
            chk("wb_layer", 32'(layer_idx), 32'(l));
            chk("wb_nodone", 32'(done), 32'd0);
            tick();
         end
         chk("t2_ld1", 32'(trace_state), 32'd5);
         chk("t2_layer", 32'(layer_idx), 32'(l + 1));
         load_layer(1'b0);
      end
      count_state(4'd2, cyc, iss);
      chk("t2_issue_last", 32'(iss), 32'd4);
      count_state(4'd3, cyc, iss);
      chk("t2_out", 32'(trace_state), 32'd6);
      chk("t2_layer2", 32'(layer_idx), 32'd2);
      hs = 0;
      for (int c = 0; c < 40 && trace_state == 4'd6; c++) begin
         out_rdy = (c >= 5) && ((c - 5) % 2 == 0);
         #1;
         chk("bp_sel", 32'(ostream_sel), 32'(hs));
         if (out_rdy) hs++;
         tick();
      end
      out_rdy = 1'b0;
      chk("bp_hs", 32'(hs), 32'd4);
      chk("bp_done", 32'({trace_state, done}), 32'h0F);
      tick();

      // cfg_nlayers=0, empty MAC entry, start ignored while busy
      cfg_nlayers = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_done = 1'b1;
      #1;
      chk("t3_noxwen", 32'(x_fifo_wen), 32'd0);
      tick();
      load_done = 1'b0;
      count_state(4'd2, cyc, iss);
      chk("t3_mac_cyc", 32'(cyc), 32'd1);
      chk("t3_mac_iss", 32'(iss), 32'd0);
      start = 1'b1;
      count_state(4'd3, cyc, iss);
      start = 1'b0;
      chk("t3_drain", 32'(cyc), 32'd3);
      chk("t3_out", 32'(trace_state), 32'd6);
      chk("t3_layer", 32'(layer_idx), 32'd0);
      out_fast();

      // Reset in the middle of writeback
      cfg_nlayers = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_layer(1'b1);
      count_state(4'd2, cyc, iss);
      count_state(4'd3, cyc, iss);
      chk("t4_wb", 32'(trace_state), 32'd4);
      tick();
      tick();
      chk("t4_sel2", 32'(ostream_sel), 32'd2);
      rst = 1'b1;
      tick();
      chk("t4_rst_outs", all_outs(), 32'd0);
      rst = 1'b0;
      cfg_nlayers = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_restart", 32'({trace_state, layer_idx}), 32'h10);
      load_layer(1'b1);
      count_state(4'd2, cyc, iss);
      chk("t4_issue", 32'(iss), 32'd4);
      count_state(4'd3, cyc, iss);
      chk("t4_drain", 32'(cyc), 32'd3);
      out_fast();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
